// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding unit for the EXE stage.
//
// Keeps a shift-register record of the destinations written by the last
// DEPTH instructions (entry 0 = MEM, entry DEPTH-1 = oldest). Each cycle it
// produces a bypass-mux select for each of NUM_SRC EXE operands and a
// load-use stall request. Both outputs are combinational from the recorded
// entries and the src_* inputs.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   advance         pipeline moves this cycle (0 = all entries hold)
//   flush           turn the incoming instruction into a bubble
//   issue_valid     instruction leaving EXE is real
//   issue_is_load   its port-0 result comes from memory
//   issue_wr_en     per-port write enable            [NUM_WR]
//   issue_wr_reg    per-port destination             [NUM_WR*REG_AW]
//   src_valid       operand s is read                [NUM_SRC]
//   src_reg         operand s register address       [NUM_SRC*REG_AW]
//   fwd_sel         per-operand select (0 = regfile, k>0 = stage (k-1)/NUM_WR,
//                   port (k-1)%NUM_WR)               [NUM_SRC*SEL_W]
//   stall           load-use hazard, EXE must hold
//
// Optional feature macro FWD_PERF_CNT_EN adds two 32-bit performance
// counters (fwd_cnt, stall_cnt).

module fwd_scoreboard #(
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SEL_W   = $clog2(DEPTH*NUM_WR+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_is_load,
  input  logic [NUM_WR-1:0]         issue_wr_en,
  input  logic [NUM_WR*REG_AW-1:0]  issue_wr_reg,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]               fwd_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  // One tracked downstream instruction.
  typedef struct packed {
    logic                     valid;
    logic                     is_load;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*REG_AW-1:0] wr_reg;
  } entry_t;

  entry_t             r_ent [DEPTH];
  entry_t             w_incoming;
  logic [SEL_W-1:0]   w_sel [NUM_SRC];
  logic [NUM_SRC-1:0] w_load_hit;

  // Incoming record; flush or an invalid issue becomes a bubble.
  always_comb begin
    w_incoming = '0;
    if (issue_valid && !flush) begin
      w_incoming.valid   = 1'b1;
      w_incoming.is_load = issue_is_load;
      w_incoming.wr_en   = issue_wr_en;
      w_incoming.wr_reg  = issue_wr_reg;
    end
  end

  // Shift register of in-flight destination records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_ent[k] <= '0;
      end
    end else if (advance) begin
      r_ent[0] <= w_incoming;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_ent[k] <= r_ent[k-1];
      end
    end
  end

  // Match search: scan oldest stage first and ports ascending so that the
  // last hit written (youngest stage, highest port) is the winner.
  always_comb begin
    logic [REG_AW-1:0] v_src;
    v_src      = '0;
    w_load_hit = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      w_sel[s] = '0;
      v_src    = src_reg[s*REG_AW +: REG_AW];
      if (src_valid[s] && (v_src != '0)) begin
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
          for (int p = 0; p < int'(NUM_WR); p++) begin
            if (r_ent[i].valid && r_ent[i].wr_en[p] &&
                (r_ent[i].wr_reg[p*REG_AW +: REG_AW] == v_src)) begin
              w_sel[s]      = SEL_W'(1 + i*int'(NUM_WR) + p);
              w_load_hit[s] = (i == 0) && (p == 0) && r_ent[i].is_load;
            end
          end
        end
      end
    end
  end

  // Flatten selects; a stage-0 port-0 load hit means data is not ready yet.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      fwd_sel[s*SEL_W +: SEL_W] = w_sel[s];
    end
    stall = |w_load_hit;
  end

`ifdef FWD_PERF_CNT_EN
  localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

  logic [CNT_W-1:0] w_fwd_num;
  logic [31:0]      r_fwd_cnt;
  logic [31:0]      r_stall_cnt;

  // Number of operands taking a bypass this cycle.
  always_comb begin
    w_fwd_num = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (w_sel[s] != '0) begin
        w_fwd_num = w_fwd_num + CNT_W'(1);
      end
    end
  end

  // Forward count accrues only on non-stalled cycles; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'(1);
    end else begin
      r_fwd_cnt   <= r_fwd_cnt + 32'(w_fwd_num);
    end
  end

  assign fwd_cnt   = r_fwd_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Define FWD_PERF_CNT_EN to also cover the performance counters.

module tb_fwd_scoreboard;

  localparam int NUM_SRC = 6;
  localparam int NUM_WR  = 2;
  localparam int REG_AW  = 4;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      advance;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_is_load;
  logic [NUM_WR-1:0]         issue_wr_en;
  logic [NUM_WR*REG_AW-1:0]  issue_wr_reg;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*REG_AW-1:0] src_reg;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]               fwd_cnt;
  logic [31:0]               stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  fwd_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_WR(NUM_WR), .REG_AW(REG_AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load),
    .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
    .src_valid(src_valid), .src_reg(src_reg),
    .fwd_sel(fwd_sel), .stall(stall)
`ifdef FWD_PERF_CNT_EN
    , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: list of recent instructions, index 0 = youngest.
  logic              mv [DEPTH];
  logic              ml [DEPTH];
  logic [NUM_WR-1:0] me [DEPTH];
  logic [REG_AW-1:0] mr [DEPTH][NUM_WR];
  logic [31:0]       m_fwd_cnt;
  logic [31:0]       m_stall_cnt;

  // Youngest instruction first, latest port first: the first hit is the answer.
  function automatic int exp_sel(int s);
    logic [REG_AW-1:0] r;
    r = src_reg[s*REG_AW +: REG_AW];
    if (!src_valid[s] || r == 0) return 0;
    for (int i = 0; i < DEPTH; i++)
      for (int p = NUM_WR - 1; p >= 0; p--)
        if (mv[i] && me[i][p] && mr[i][p] == r) return 1 + i*NUM_WR + p;
    return 0;
  endfunction

  // Select 1 means MEM-stage port 0; stall when that is a load.
  function automatic bit exp_stall();
    for (int s = 0; s < NUM_SRC; s++)
      if (exp_sel(s) == 1 && ml[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_nfwd();
    int n = 0;
    for (int s = 0; s < NUM_SRC; s++) if (exp_sel(s) != 0) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mv[i] <= 1'b0;
        ml[i] <= 1'b0;
        me[i] <= '0;
        for (int p = 0; p < NUM_WR; p++) mr[i][p] <= '0;
      end
      m_fwd_cnt   <= '0;
      m_stall_cnt <= '0;
    end else begin
      if (exp_stall()) m_stall_cnt <= m_stall_cnt + 1;
      else             m_fwd_cnt   <= m_fwd_cnt + 32'(exp_nfwd());
      if (advance) begin
        mv[0] <= issue_valid && !flush;
        ml[0] <= issue_is_load;
        me[0] <= (issue_valid && !flush) ? issue_wr_en : '0;
        for (int p = 0; p < NUM_WR; p++) mr[0][p] <= issue_wr_reg[p*REG_AW +: REG_AW];
        for (int i = DEPTH - 1; i >= 1; i--) begin
          mv[i] <= mv[i-1];
          ml[i] <= ml[i-1];
          me[i] <= me[i-1];
          for (int p = 0; p < NUM_WR; p++) mr[i][p] <= mr[i-1][p];
        end
      end
    end
  end

  // Compare process: every cycle, every operand, plus stall and counters.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        total++;
        if (int'(fwd_sel[s*SEL_W +: SEL_W]) !== exp_sel(s)) begin
          bad++;
          $display("FAIL model_sel[%0d] t=%0t: got %0d expected %0d",
                   s, $time, fwd_sel[s*SEL_W +: SEL_W], exp_sel(s));
        end
      end
      total++;
      if (stall !== exp_stall()) begin
        bad++;
        $display("FAIL model_stall t=%0t: got %0b expected %0b", $time, stall, exp_stall());
      end
`ifdef FWD_PERF_CNT_EN
      total++;
      if (fwd_cnt !== m_fwd_cnt || stall_cnt !== m_stall_cnt) begin
        bad++;
        $display("FAIL model_cnt t=%0t: got fwd=%0d stall=%0d expected fwd=%0d stall=%0d",
                 $time, fwd_cnt, stall_cnt, m_fwd_cnt, m_stall_cnt);
      end
`endif
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_src();
    src_valid = '0;
    src_reg   = '0;
  endtask

  task automatic set_src(int s, int r);
    src_valid[s] = 1'b1;
    src_reg[s*REG_AW +: REG_AW] = REG_AW'(r);
  endtask

  task automatic set_iss(logic v, logic ld, logic [NUM_WR-1:0] en, int r0, int r1);
    issue_valid   = v;
    issue_is_load = ld;
    issue_wr_en   = en;
    issue_wr_reg  = {REG_AW'(r1), REG_AW'(r0)};
  endtask

  function automatic int sel_of(int s);
    return int'(fwd_sel[s*SEL_W +: SEL_W]);
  endfunction

  initial begin
    rst_n = 1'b1;
    advance = 1'b1;
    flush = 1'b0;
    set_iss(1'b0, 1'b0, '0, 0, 0);
    clr_src();
    #2;
    rst_n = 1'b0;
    #1;
    chk_on = 1'b1;

    // Reset holds everything at zero even with live inputs.
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 3);
    set_iss(1'b1, 1'b1, 2'b01, 3, 3);
    sample();
    chk("reset_sel", int'(fwd_sel), 0);
    chk("reset_stall", int'(stall), 0);
    step();
    rst_n = 1'b1;
    set_iss(1'b1, 1'b0, 2'b01, 3, 0);
    sample();
    chk("post_reset_sel0", sel_of(0), 0);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("first_issue_sel0", sel_of(0), 1);
    chk("first_issue_sel5", sel_of(5), 1);
    chk("model_pin_first", exp_sel(0), 1);

    // Age priority.
    clr_src();
    set_src(0, 5);
    set_iss(1'b1, 1'b0, 2'b01, 5, 0);
    step();
    set_iss(1'b1, 1'b0, 2'b10, 0, 5);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("age_sel", sel_of(0), 2);
    step();
    sample();
    chk("age_stage1_sel", sel_of(0), 4);
    chk("model_pin_age", exp_sel(0), 4);

    // Port priority within one instruction.
    clr_src();
    set_src(0, 7);
    set_iss(1'b1, 1'b0, 2'b11, 7, 7);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("port_sel", sel_of(0), 2);

    // Load-use stall then release.
    clr_src();
    set_src(0, 9);
    set_iss(1'b1, 1'b1, 2'b01, 9, 0);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("ld_stall", int'(stall), 1);
    chk("ld_sel", sel_of(0), 1);
    chk("model_pin_stall", int'(exp_stall()), 1);
    step();
    sample();
    chk("ld_release_stall", int'(stall), 0);
    chk("ld_release_sel", sel_of(0), 3);

    // Hold, even with a flushed issue present.
    clr_src();
    set_src(0, 6);
    set_iss(1'b1, 1'b0, 2'b01, 6, 0);
    step();
    advance = 1'b0;
    flush = 1'b1;
    set_iss(1'b1, 1'b0, 2'b10, 0, 6);
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("hold_sel", sel_of(0), 1);
      step();
    end

    // Flush beats issue_valid.
    advance = 1'b1;
    clr_src();
    set_src(0, 4);
    set_iss(1'b1, 1'b0, 2'b01, 4, 0);
    step();
    flush = 1'b0;
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("flush_sel", sel_of(0), 0);

    // Register 0 never forwards.
    clr_src();
    set_src(0, 0);
    set_iss(1'b1, 1'b0, 2'b11, 0, 0);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    sample();
    chk("r0_sel", sel_of(0), 0);

`ifdef FWD_PERF_CNT_EN
    // Two forwarded operands held for three cycles.
    step();
    rst_n = 1'b0;
    clr_src();
    step();
    rst_n = 1'b1;
    set_iss(1'b1, 1'b0, 2'b11, 10, 11);
    step();
    set_iss(1'b0, 1'b0, '0, 0, 0);
    advance = 1'b0;
    set_src(0, 10);
    set_src(1, 11);
    step();
    step();
    step();
    sample();
    chk("cnt_fwd", int'(fwd_cnt), 6);
    chk("cnt_stall", int'(stall_cnt), 0);
    advance = 1'b1;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      advance       = ($urandom_range(7) != 0);
      flush         = ($urandom_range(7) == 0);
      issue_valid   = $urandom_range(1);
      issue_is_load = ($urandom_range(3) == 0);
      issue_wr_en   = NUM_WR'($urandom_range(3));
      for (int p = 0; p < NUM_WR; p++)
        issue_wr_reg[p*REG_AW +: REG_AW] = REG_AW'($urandom_range(7));
      for (int s = 0; s < NUM_SRC; s++) begin
        src_valid[s] = ($urandom_range(3) != 0);
        src_reg[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(7));
      end
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    sample();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
